// File: rtl/light_sequencer.sv
// light_sequencer: steps a writable multi-line pattern memory on a prescaled tick with run/pause/stop control.
module light_sequencer #(
  parameter int LINES    = 4,
  parameter int STEPS    = 60,
  parameter int STEP_W   = 6,
  parameter int PRESCALE = 1000000,
  parameter int PRE_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_mode,
  input  logic              dir,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [LINES-1:0]  wr_data,
  output logic [LINES-1:0]  lines,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [PRE_W-1:0]  LAST_PRE  = PRE_W'(PRESCALE - 1);
  state_t state, state_nx;
  logic [STEP_W-1:0] step_nx;
  logic [PRE_W-1:0] pre, pre_nx;
  logic done_nx, tick, at_end;
  // Sized to the full index range so step always indexes cleanly; slots at or above STEPS stay zero.
  logic [LINES-1:0] mem [2**STEP_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      pre   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < 2**STEP_W; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      pre   <= pre_nx;
      done  <= done_nx;
      if (wr_en && wr_addr <= LAST_STEP) mem[wr_addr] <= wr_data;
    end
  end
  // The cycle that releases pause counts as a run cycle, so each paused cycle adds exactly one to the period.
  assign tick   = state != IDLE && !pause && pre == LAST_PRE;
  assign at_end = dir ? step == '0 : step == LAST_STEP;
  always_comb begin
    state_nx = state;
    step_nx  = step;
    pre_nx   = pre;
    done_nx  = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      pre_nx   = '0;
    end else if (state == IDLE) begin
      if (start) begin
        state_nx = RUN;
        step_nx  = dir ? LAST_STEP : '0;
        pre_nx   = '0;
      end
    end else if (pause) begin
      state_nx = PAUSE;
    end else begin
      state_nx = RUN;
      pre_nx   = tick ? '0 : pre + 1'b1;
      if (tick && !at_end) step_nx = dir ? step - 1'b1 : step + 1'b1;
      else if (tick && loop_mode) step_nx = dir ? LAST_STEP : '0;
      else if (tick) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end
  end
  always_comb begin
    busy  = state != IDLE;
    lines = busy ? mem[step] : '0;
  end
endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed and randomized checks of light_sequencer against a cycle-count reference model.
module tb_light_sequencer;
  localparam int LINES = 4, STEPS = 4, STEP_W = 3, PRESCALE = 3, PRE_W = 2;
  logic clk = 0, reset = 0, start = 0, stop = 0, pause = 0, loop_mode = 0, dir = 0, wr_en = 0;
  logic [STEP_W-1:0] wr_addr = '0;
  logic [LINES-1:0] wr_data = '0;
  logic [LINES-1:0] lines;
  logic [STEP_W-1:0] step;
  logic busy, done;
  int checks = 0, errors = 0;
  int m_mem [STEPS];
  bit m_active, m_done;
  int m_step, m_cnt;

  light_sequencer #(.LINES(LINES), .STEPS(STEPS), .STEP_W(STEP_W), .PRESCALE(PRESCALE), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .loop_mode(loop_mode),
    .dir(dir), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lines(lines), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: counts active cycles within a step; position moves by +/-1 modulo STEPS.
  task automatic model_edge();
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_active = 0; m_done = 0; m_step = 0; m_cnt = 0;
      return;
    end
    m_done = 0;
    if (wr_en && int'(wr_addr) < STEPS) m_mem[wr_addr] = int'(wr_data);
    if (stop) begin
      m_active = 0; m_cnt = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_cnt = 0; m_step = dir ? STEPS - 1 : 0;
      end
    end else if (!pause) begin
      m_cnt++;
      if (m_cnt == PRESCALE) begin
        m_cnt = 0;
        m_step += dir ? -1 : 1;
        if (m_step < 0 || m_step >= STEPS) begin
          if (loop_mode) m_step = (m_step + STEPS) % STEPS;
          else begin
            m_step = dir ? 0 : STEPS - 1;
            m_active = 0; m_done = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [LINES+STEP_W+1:0] exp_vec();
    return {m_active ? LINES'(m_mem[m_step]) : LINES'(0), STEP_W'(m_step), m_active, m_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {reset, start, stop, pause, wr_en} = '0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    checks++;
    if ({lines, step, busy, done} !== '0) begin
      errors++; $display("FAIL reset: got %h required 0", {lines, step, busy, done});
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_addr = i < 4 ? STEP_W'(i) : STEP_W'(5); wr_data = i < 4 ? LINES'(1 << i) : 4'hA;
      tick();
      checks++;
      if ({lines, step, busy, done} !== exp_vec() || busy !== 0 || lines !== 0) begin
        errors++; $display("FAIL write %0d: got %h required %h", i, {lines, step, busy, done}, exp_vec());
      end
    end
    wr_en = 0;
  endtask

  task automatic test_ascending_oneshot();
    int pulses = 0;
    dir = 0; loop_mode = 0; start = 1; tick(); start = 0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      pulses += int'(done);
      checks++;
      if ({lines, step, busy, done} !== exp_vec()) begin
        errors++; $display("FAIL asc_model k=%0d: got %h required %h", k, {lines, step, busy, done}, exp_vec());
      end
      checks++;
      if (k < 12 && lines !== LINES'(1 << (k / 3))) begin
        errors++; $display("FAIL asc_lines k=%0d: got %h required %h", k, lines, 1 << (k / 3));
      end else if (k >= 12 && {lines, step, busy, done} !== {4'h0, 3'd3, 1'b0, k == 12}) begin
        errors++; $display("FAIL asc_end k=%0d: got %h required %h", k, {lines, step, busy, done}, {4'h0, 3'd3, 1'b0, k == 12});
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL asc_done_count: got %0d required 1", pulses);
    end
  endtask

  task automatic test_descending_loop();
    dir = 1; loop_mode = 1; start = 1; tick(); start = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      checks++;
      if ({lines, step, busy, done} !== exp_vec() ||
          {lines, step, busy, done} !== {LINES'(8 >> ((k / 3) % 4)), STEP_W'(3 - (k / 3) % 4), 1'b1, 1'b0}) begin
        errors++; $display("FAIL desc_loop k=%0d: got %h required %h", k, {lines, step, busy, done}, exp_vec());
      end
    end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_pause_stop();
    dir = 0; loop_mode = 1; start = 1; tick(); start = 0;
    tick();
    pause = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({lines, step, busy} !== {4'h1, 3'd0, 1'b1} || {lines, step, busy, done} !== exp_vec()) begin
        errors++; $display("FAIL pause_hold k=%0d: got %h required %h", k, {lines, step, busy, done}, exp_vec());
      end
    end
    pause = 0;
    tick();
    checks++;
    if (step !== 0) begin
      errors++; $display("FAIL pause_stretch_early: got %0d required 0", step);
    end
    tick();
    checks++;
    if (step !== 1 || lines !== 4'h2) begin
      errors++; $display("FAIL pause_stretch_change: got step %0d lines %h required 1/2", step, lines);
    end
    pause = 1; tick(); tick();
    stop = 1; tick(); stop = 0; pause = 0;
    checks++;
    if ({lines, step, busy, done} !== {4'h0, 3'd1, 1'b0, 1'b0} || {lines, step, busy, done} !== exp_vec()) begin
      errors++; $display("FAIL stop_in_pause: got %h required %h", {lines, step, busy, done}, exp_vec());
    end
  endtask

  task automatic test_live_write();
    dir = 0; loop_mode = 1; start = 1; tick(); start = 0;
    repeat (6) tick();
    wr_en = 1; wr_addr = 3'd2; wr_data = 4'hF; tick(); wr_en = 0;
    checks++;
    if (step !== 2 || lines !== 4'hF || {lines, step, busy, done} !== exp_vec()) begin
      errors++; $display("FAIL live_write: got step %0d lines %h required 2/F", step, lines);
    end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_start_stop();
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    checks++;
    if (busy !== 0 || lines !== 0 || {lines, step, busy, done} !== exp_vec()) begin
      errors++; $display("FAIL start_stop: got busy %b lines %h required 0/0", busy, lines);
    end
  endtask

  task automatic test_mid_reset();
    dir = 0; loop_mode = 1; start = 1; tick(); start = 0;
    repeat (4) tick();
    reset = 1; tick(); reset = 0;
    checks++;
    if ({lines, step, busy, done} !== '0) begin
      errors++; $display("FAIL mid_reset: got %h required 0", {lines, step, busy, done});
    end
    start = 1; tick(); start = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (busy !== 1 || lines !== 0 || {lines, step, busy, done} !== exp_vec()) begin
        errors++; $display("FAIL mem_cleared k=%0d: got busy %b lines %h required 1/0", k, busy, lines);
      end
    end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset = $urandom_range(0, 149) == 0;
      start = $urandom_range(0, 3) == 0;
      stop = $urandom_range(0, 24) == 0;
      pause = $urandom_range(0, 5) == 0;
      loop_mode = $urandom_range(0, 3) != 0;
      dir = $urandom_range(0, 1) == 1;
      wr_en = $urandom_range(0, 3) == 0;
      wr_addr = STEP_W'($urandom_range(0, 7));
      wr_data = LINES'($urandom);
      tick();
      checks++;
      if ({lines, step, busy, done} !== exp_vec()) begin
        errors++; $display("FAIL random k=%0d: got %h required %h", k, {lines, step, busy, done}, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write();
    test_ascending_oneshot();
    test_descending_loop();
    test_pause_stop();
    test_live_write();
    test_start_stop();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/light_sequencer.md
# light_sequencer

Parametrised multi-line light pattern sequencer for the light-display datapath. It holds a writable pattern memory of STEPS words, each LINES bits wide, and steps through it on a programmable prescaled tick. Each memory word drives all light lines at once. It adds run control that a fixed selector-to-line decoder does not have: start/stop/pause, loop or one-shot mode, up or down direction, and a done pulse. It sits between the control/counter logic and the physical light lines.

## Interface
- LINES, default 4: number of light lines (output width).
- STEPS, default 60: number of pattern steps, 1..64.
- STEP_W, default 6: step index width; must satisfy 2^STEP_W >= STEPS.
- PRESCALE, default 1000000: clock cycles per step, >= 1.
- PRE_W, default 20: prescaler width; must satisfy 2^PRE_W >= PRESCALE.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: begin a sequence; honoured only in IDLE.
- stop, in, 1: abort to IDLE from any state.
- pause, in, 1: level; freezes the sequence while high.
- loop_mode, in, 1: 1 = wrap at end, 0 = one-shot.
- dir, in, 1: 0 = ascending steps, 1 = descending.
- wr_en, in, 1: pattern memory write strobe.
- wr_addr, in, STEP_W: write step index.
- wr_data, in, LINES: write pattern word.
- lines, out, LINES: light line drive.
- step, out, STEP_W: current step index.
- busy, out, 1: high in RUN or PAUSE.
- done, out, 1: one-cycle pulse at one-shot completion.

## Operation
- Registers: state (IDLE/RUN/PAUSE), step, prescaler count, pattern memory mem[0..STEPS-1].
- lines = mem[step] when state != IDLE; lines = 0 in IDLE. This is combinational from registers.
- Reset (synchronous): state=IDLE, step=0, prescaler=0, all mem words=0, done=0. Resulting outputs: lines=0, step=0, busy=0, done=0.
- Memory write: when wr_en=1 and wr_addr<STEPS, mem[wr_addr]<=wr_data. Writes are allowed in any state. If wr_addr>=STEPS the write is ignored.
- IDLE:
  - start=1 and stop=0 -> RUN.
  - step <= 0 if dir=0, or STEPS-1 if dir=1.
  - prescaler <= 0.
- RUN:
  - prescaler increments each cycle.
  - When prescaler = PRESCALE-1 a tick occurs: prescaler <= 0 and the step advances.
- Step advance on tick. dir and loop_mode are sampled at the tick.
  - dir=0, step<STEPS-1: step+1.
  - dir=1, step>0: step-1.
  - At the end step (STEPS-1 ascending, 0 descending):
    - loop_mode=1: wrap to 0 (ascending) or STEPS-1 (descending).
    - loop_mode=0: done<=1 for one cycle, state<=IDLE, step unchanged.
- PAUSE:
  - Entered from RUN when pause=1; returns to RUN when pause=0.
  - Prescaler and step are held; lines keep showing mem[step].
  - A tick due in the same cycle that pause is sampled high is suppressed.
- stop=1: state<=IDLE and prescaler<=0 from any state. step keeps its value. stop has priority over start, pause and tick.
- start in RUN or PAUSE is ignored.
- busy = (state==RUN || state==PAUSE).

## Timing
- start sampled at edge E: busy=1 and lines=mem[first step] after E.
- First step change occurs PRESCALE edges after E; each later step change follows every PRESCALE cycles of RUN.
- Pause cycles add exactly their count to the step period.
- Memory write at edge E is visible on lines after E if wr_addr==step. Write-through has zero extra latency.
- One-shot end: done is high for exactly the cycle after the final tick edge, with busy=0 in that same cycle. start is accepted in that cycle.
- PRESCALE=1: the step advances every RUN cycle.
- STEPS=1:
  - Loop mode: step stays 0 and ticks repeat.
  - One-shot: done fires after PRESCALE cycles.
- Reset asserted mid-sequence: all registers, including mem, return to reset values on that edge. Reset overrides every other input.
- No combinational path from inputs to outputs, except from register state to lines.

## Test plan
- Test build: LINES=4, STEPS=4, PRESCALE=3.
- Reset and write:
  - reset, then write mem = 1,2,4,8 at addresses 0..3: lines=0, busy=0.
  - Write to wr_addr=5: no change to mem.
- Ascending one-shot:
  - start with dir=0, loop_mode=0: lines=1,2,4,8, each held 3 cycles.
  - done pulses once after 12 cycles; then busy=0, lines=0, step=3.
- Descending loop:
  - dir=1, loop_mode=1, start: steps 3,2,1,0,3 with lines=8,4,2,1,8.
  - done never asserts.
- Pause and stop:
  - pause=1 for 5 cycles mid-step: step period stretches from 3 to 8 cycles, lines held.
  - stop during pause: IDLE next cycle, lines=0, step retained.
- Live write: in RUN at step 2, write wr_addr=2, wr_data=4'hF: lines=F the next cycle.
- Simultaneous events and mid-run reset:
  - start and stop in the same IDLE cycle: stays IDLE.
  - reset mid-RUN: all outputs return to 0; mem reads all zero.
